// File: rtl/fetch_redirect_ctrl_pkg.sv
// Purpose : shared types and opcodes for the fetch redirect controller.
// Latency : n/a (types, constants and one pure helper function only).
// Backpr. : n/a.
// Contents: redir_state_t, pc_sel_t, OPC_JAL/OPC_JALR, is_jump().
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} redir_state_t;

    typedef enum logic [1:0] {SEL_SEQ, SEL_ALU, SEL_TRAP, SEL_EPC} pc_sel_t;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    function automatic logic is_jump(input logic [6:0] opc);
        return (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Purpose : bundle between the EX stage / PC register and the redirect controller.
// Latency : n/a (wires only).
// Backpr. : mem_stall from data memory; stall_pc back to the PC and IF/EX registers.
// Modports: slave = controller side, master = pipeline side.
// With REDIRECT_CNT_EN defined, the redirect_cnt/trap_cnt counter outputs are added.
interface fetch_redirect_ctrl_if #(parameter int XLEN = 32);
    import fetch_ctrl_pkg::*;

    logic [6:0]      opcode_ex;
    logic            br_taken;
    logic [XLEN-1:0] alu_target;
    logic [XLEN-1:0] pc_ex;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic            mret;
    logic [XLEN-1:0] mepc;
    logic            mem_stall;
    pc_sel_t         pc_sel;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_valid;
    logic            stall_pc;
    logic            flush_if;
    logic            flush_ex;
    logic            trap_ack;
    logic [XLEN-1:0] epc_out;
`ifdef REDIRECT_CNT_EN
    logic [31:0]     redirect_cnt;
    logic [31:0]     trap_cnt;

    modport slave (
        input  opcode_ex, br_taken, alu_target, pc_ex, trap_req, trap_vec, mret, mepc, mem_stall,
        output pc_sel, redirect_pc, redirect_valid, stall_pc, flush_if, flush_ex, trap_ack, epc_out,
               redirect_cnt, trap_cnt
    );
    modport master (
        output opcode_ex, br_taken, alu_target, pc_ex, trap_req, trap_vec, mret, mepc, mem_stall,
        input  pc_sel, redirect_pc, redirect_valid, stall_pc, flush_if, flush_ex, trap_ack, epc_out,
               redirect_cnt, trap_cnt
    );
`else
    modport slave (
        input  opcode_ex, br_taken, alu_target, pc_ex, trap_req, trap_vec, mret, mepc, mem_stall,
        output pc_sel, redirect_pc, redirect_valid, stall_pc, flush_if, flush_ex, trap_ack, epc_out
    );
    modport master (
        output opcode_ex, br_taken, alu_target, pc_ex, trap_req, trap_vec, mret, mepc, mem_stall,
        input  pc_sel, redirect_pc, redirect_valid, stall_pc, flush_if, flush_ex, trap_ack, epc_out
    );
`endif

endinterface

// File: rtl/fetch_redirect_ctrl_perf_cnt.sv
// Purpose : free-running redirect and trap-entry event counters (wrap modulo 2^32).
// Latency : count visible the cycle after the event.
// Backpr. : none; counts every strobe presented.
// Ports   : clk, reset, inc_redirect_i, inc_trap_i -> redirect_cnt_o, trap_cnt_o.
module redirect_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_redirect_i,
    input  logic        inc_trap_i,
    output logic [31:0] redirect_cnt_o,
    output logic [31:0] trap_cnt_o
);

    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] trap_cnt_q, trap_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q + {31'd0, inc_redirect_i};
        trap_cnt_d     = trap_cnt_q + {31'd0, inc_trap_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt_q <= 32'd0;
            trap_cnt_q     <= 32'd0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            trap_cnt_q     <= trap_cnt_d;
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;
    assign trap_cnt_o     = trap_cnt_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Purpose : fetch PC sequencer; arbitrates trap > mret > jump/branch > mem_stall, flushes after redirects.
// Latency : redirect_valid/pc_sel/redirect_pc/flush_if same cycle; trap_ack/epc_out/flush_ex registered.
// Backpr. : mem_stall raises stall_pc and freezes STALL/FLUSH; a redirect wins over a same-cycle stall.
// Ports   : clk, reset (sync, active-high), bus (fetch_redirect_ctrl_if.slave).
// Option  : REDIRECT_CNT_EN adds redirect_cnt/trap_cnt via redirect_perf_cnt.
module fetch_redirect_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              FLUSH_CYCLES = 1,
    parameter logic [XLEN-1:0] RESET_VEC    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_redirect_ctrl_if.slave  bus
);

    redir_state_t    state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pvec_q, pvec_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            ack_q, ack_d;

    pc_sel_t         sel;
    logic [XLEN-1:0] rpc;
    logic            rvld;
    logic            stall;
    logic            fex;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pvec_d  = pvec_q;
        epc_d   = epc_q;
        ack_d   = 1'b0;
        sel     = SEL_SEQ;
        rpc     = RESET_VEC;
        rvld    = 1'b0;
        stall   = 1'b0;
        fex     = 1'b0;
        // Gating with reset keeps every output quiet while reset is held,
        // even before the synchronous reset has taken effect on state_q.
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (bus.trap_req || pend_q) begin
                        // A trap latched during a stall uses the vector seen then.
                        sel     = SEL_TRAP;
                        rpc     = pend_q ? pvec_q : bus.trap_vec;
                        rvld    = 1'b1;
                        ack_d   = 1'b1;
                        epc_d   = bus.pc_ex;
                        pend_d  = 1'b0;
                    end else if (bus.mret) begin
                        sel     = SEL_EPC;
                        rpc     = bus.mepc;
                        rvld    = 1'b1;
                    end else if (is_jump(bus.opcode_ex) || bus.br_taken) begin
                        sel     = SEL_ALU;
                        rpc     = bus.alu_target;
                        rvld    = 1'b1;
                    end else if (bus.mem_stall) begin
                        stall   = 1'b1;
                        state_d = STALL;
                    end
                    // Redirect beats a coincident mem_stall; FLUSH then sees the stall.
                    if (rvld) begin
                        state_d = FLUSH;
                        cnt_d   = 2'(FLUSH_CYCLES);
                    end
                end
                STALL: begin
                    // EX is held, so only a trap needs remembering; jumps re-evaluate in RUN.
                    stall = 1'b1;
                    if (bus.trap_req) begin
                        pend_d = 1'b1;
                        pvec_d = bus.trap_vec;
                    end
                    if (!bus.mem_stall) begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    fex = 1'b1;
                    if (bus.mem_stall) begin
                        stall = 1'b1;
                    end else if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            pend_q  <= 1'b0;
            pvec_q  <= RESET_VEC;
            epc_q   <= RESET_VEC;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pvec_q  <= pvec_d;
            epc_q   <= epc_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.pc_sel         = sel;
    assign bus.redirect_pc    = rpc;
    assign bus.redirect_valid = rvld;
    assign bus.flush_if       = rvld;
    assign bus.stall_pc       = stall;
    assign bus.flush_ex       = fex;
    assign bus.trap_ack       = ack_q;
    assign bus.epc_out        = epc_q;

`ifdef REDIRECT_CNT_EN
    redirect_perf_cnt u_perf_cnt (
        .clk            (clk),
        .reset          (reset),
        .inc_redirect_i (rvld),
        .inc_trap_i     (ack_q),
        .redirect_cnt_o (bus.redirect_cnt),
        .trap_cnt_o     (bus.trap_cnt)
    );
`endif

endmodule
